// File: rtl/result_packet_writer_if.sv
// Handshake and memory-write bundle for the result packet writer.
// master drives packets and memory ready; slave is the writer itself.
interface result_packet_writer_if;
    logic [31:0] base_addr;
    logic        base_valid;
    logic [31:0] data_in;
    logic        data_valid;
    logic        pkt_end;
    logic        data_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        mem_ready;
    logic        inc_addr;
    logic        overflow;

    modport master (
        output base_addr, base_valid, data_in, data_valid, pkt_end,
        output mem_ready,
        input  data_ready, mem_addr, mem_wdata, mem_wr, inc_addr, overflow
    );

    modport slave (
        input  base_addr, base_valid, data_in, data_valid, pkt_end,
        input  mem_ready,
        output data_ready, mem_addr, mem_wdata, mem_wr, inc_addr, overflow
    );
endinterface

// File: rtl/result_packet_writer.sv
// Buffers packet words and writes them into a fixed-size result slot.
// Macro RESULT_WRITER_LEN_HEADER_EN adds a leading byte-length header word.
module result_packet_writer #(
    parameter int SLOT_BYTES = 1550,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   n_rst,
    result_packet_writer_if.slave bus
);

`ifdef RESULT_WRITER_LEN_HEADER_EN
    localparam int OFF = 4;
    localparam int MAXW = (SLOT_BYTES - 4) / 4;
    typedef enum logic [1:0] {IDLE, DATA, HEADER, DONE} state_t;
`else
    localparam int OFF = 0;
    localparam int MAXW = SLOT_BYTES / 4;
    typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;
`endif

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] MAX_W = 10'(MAXW);

    state_t        state_q;
    logic [31:0]   base_reg_q;
    logic          base_ok_q;
    logic [31:0]   pkt_base_q;
    logic [9:0]    wcount_q;
    logic          overflow_q;
    logic          last_acc_q;
    logic [32:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   cnt_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          ready;
    logic          accept;
    logic [32:0]   head;
    logic          in_data;
    logic          can_wr;
    logic          pop;
    logic [31:0]   wr_addr;

    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign ready      = !fifo_full && base_ok_q && !last_acc_q &&
                        (state_q == IDLE || state_q == DATA);
    assign accept     = bus.data_valid && ready;
    assign head       = fifo_q[rd_ptr_q];
    assign in_data    = (state_q == DATA) && !fifo_empty;
    assign can_wr     = (wcount_q < MAX_W);
    assign pop        = in_data && (!can_wr || bus.mem_ready);
    assign wr_addr    = pkt_base_q + 32'(OFF) + {20'b0, wcount_q, 2'b00};

    // Drive the memory port from the current head word or the header.
    always_comb begin
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (in_data && can_wr) begin
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = head[31:0];
        end
`ifdef RESULT_WRITER_LEN_HEADER_EN
        if (state_q == HEADER) begin
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = pkt_base_q;
            bus.mem_wdata = {20'b0, wcount_q, 2'b00};
        end
`endif
    end

    assign bus.data_ready = ready;
    assign bus.inc_addr   = (state_q == DONE);
    assign bus.overflow   = overflow_q;

    // FIFO storage; occupancy is tracked by the pointers below.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= {bus.pkt_end, bus.data_in};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Slot base bookkeeping; a new base wins over the clear in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base_reg_q <= '0;
            base_ok_q  <= 1'b0;
            last_acc_q <= 1'b0;
        end else begin
            if (bus.base_valid) begin
                base_reg_q <= bus.base_addr;
                base_ok_q  <= 1'b1;
            end else if (state_q == DONE) begin
                base_ok_q  <= 1'b0;
            end
            if (state_q == DONE) begin
                last_acc_q <= 1'b0;
            end else if (accept && bus.pkt_end) begin
                last_acc_q <= 1'b1;
            end
        end
    end

    // Packet sequencing: data words, optional header, slot advance.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            pkt_base_q <= '0;
            wcount_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        pkt_base_q <= base_reg_q;
                        wcount_q   <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (can_wr) wcount_q <= wcount_q + 10'd1;
                        else overflow_q <= 1'b1;
`ifdef RESULT_WRITER_LEN_HEADER_EN
                        if (head[32]) state_q <= HEADER;
`else
                        if (head[32]) state_q <= DONE;
`endif
                    end
                end
`ifdef RESULT_WRITER_LEN_HEADER_EN
                HEADER: begin
                    if (bus.mem_ready) state_q <= DONE;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_packet_writer.sv
// Directed bench for result_packet_writer with a per-packet write model.
// Honours RESULT_WRITER_LEN_HEADER_EN the same way the design does.
module tb_result_packet_writer;

    localparam int SLOT = 1550;
`ifdef RESULT_WRITER_LEN_HEADER_EN
    localparam bit HDR = 1'b1;
    localparam int OFF = 4;
    localparam int MAXW = (SLOT - 4) / 4;
`else
    localparam bit HDR = 1'b0;
    localparam int OFF = 0;
    localparam int MAXW = SLOT / 4;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    result_packet_writer_if bus ();

    result_packet_writer #(.SLOT_BYTES(SLOT), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int inc_seen = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_d = '0;
    wr_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Expected memory writes of one packet, straight from the slot layout.
    task automatic model_pkt(input logic [31:0] base, input int n,
                             input logic [31:0] seed);
        int k;
        k = (n < MAXW) ? n : MAXW;
        for (int i = 0; i < k; i++)
            exp_q.push_back('{base + 32'(OFF) + 32'(4 * i), seed + 32'(i)});
        if (HDR) exp_q.push_back('{base, 32'(4 * k)});
    endtask

    // Compare process: every observed write must match the model in order.
    initial begin
        logic pend;
        logic [31:0] p_a, p_d;
        pend = 1'b0;
        p_a = '0;
        p_d = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("hold wr", {31'b0, bus.mem_wr}, 32'd1);
                    chk("hold addr", bus.mem_addr, p_a);
                    chk("hold data", bus.mem_wdata, p_d);
                end
                if (bus.mem_wr === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray write: addr %h data %h, none expected",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        chk("wr addr", bus.mem_addr, exp_q[0].a);
                        chk("wr data", bus.mem_wdata, exp_q[0].d);
                        if (bus.mem_ready === 1'b1) begin
                            void'(exp_q.pop_front());
                            wr_seen++;
                            last_a = bus.mem_addr;
                            last_d = bus.mem_wdata;
                        end
                    end
                end
                pend = (bus.mem_wr === 1'b1) && (bus.mem_ready !== 1'b1);
                p_a = bus.mem_addr;
                p_d = bus.mem_wdata;
                if (bus.inc_addr === 1'b1) inc_seen++;
            end
        end
    end

    task automatic base_pulse(input logic [31:0] b);
        bus.base_addr = b;
        bus.base_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.base_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic e);
        int t;
        t = 0;
        bus.data_in = d;
        bus.pkt_end = e;
        bus.data_valid = 1'b1;
        @(negedge clk);
        while (bus.data_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: data_ready %b required 1", bus.data_ready);
        end
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.pkt_end = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] seed);
        for (int i = 0; i < n; i++) send_word(seed + 32'(i), i == n - 1);
    endtask

    task automatic wait_inc(input string nm);
        int t;
        t = 0;
        while (bus.inc_addr !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: inc_addr %b required 1 within budget", nm, bus.inc_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " data_ready"}, {31'b0, bus.data_ready}, 32'd0);
        chk({nm, " mem_wr"}, {31'b0, bus.mem_wr}, 32'd0);
        chk({nm, " mem_addr"}, bus.mem_addr, 32'd0);
        chk({nm, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({nm, " inc_addr"}, {31'b0, bus.inc_addr}, 32'd0);
        chk({nm, " overflow"}, {31'b0, bus.overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int inc0;
        bus.base_addr = '0;
        bus.base_valid = 1'b0;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        bus.pkt_end = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Short packet at an unaligned slot base.
        w0 = wr_seen;
        model_pkt(HDR ? 32'h060E : 32'h0C1C, HDR ? 3 : 2, 32'hA0);
        base_pulse(HDR ? 32'h060E : 32'h0C1C);
        send_pkt(HDR ? 3 : 2, 32'hA0);
        wait_inc("t1 inc");
        chk("t1 inc width", {31'b0, bus.inc_addr}, 32'd0);
        chk("t1 writes", 32'(wr_seen - w0), HDR ? 32'd4 : 32'd2);
        chk("t1 last addr", last_a, HDR ? 32'h060E : 32'h0C20);
        chk("t1 last data", last_d, HDR ? 32'd12 : 32'hA1);
        chk("t1 overflow", {31'b0, bus.overflow}, 32'd0);

        // Memory back-pressure fills the FIFO.
        w0 = wr_seen;
        model_pkt(32'h100, 6, 32'hB0);
        base_pulse(32'h100);
        bus.mem_ready = 1'b0;
        fork
            send_pkt(6, 32'hB0);
            begin
                repeat (7) @(negedge clk);
                chk("t2 full ready", {31'b0, bus.data_ready}, 32'd0);
                chk("t2 stall wr", {31'b0, bus.mem_wr}, 32'd1);
                chk("t2 stall addr", bus.mem_addr, 32'h100 + 32'(OFF));
                chk("t2 stall data", bus.mem_wdata, 32'hB0);
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b1;
            end
        join
        wait_inc("t2 inc");
        chk("t2 writes", 32'(wr_seen - w0), HDR ? 32'd7 : 32'd6);

        // Oversized packet truncated at the slot end.
        w0 = wr_seen;
        model_pkt(32'h0, 400, 32'h1000);
        base_pulse(32'h0);
        send_pkt(400, 32'h1000);
        wait_inc("t3 inc");
        chk("t3 writes", 32'(wr_seen - w0), 32'd387);
        chk("t3 last addr", last_a, HDR ? 32'h0 : 32'h608);
        chk("t3 last data", last_d, HDR ? 32'd1544 : 32'h1182);
        chk("t3 overflow", {31'b0, bus.overflow}, 32'd1);

        model_pkt(32'h200, 2, 32'h20);
        base_pulse(32'h200);
        send_pkt(2, 32'h20);
        wait_inc("t3b inc");
        chk("t3b overflow", {31'b0, bus.overflow}, 32'd0);

        // Back-to-back packets; the second waits for its own base.
        model_pkt(32'h300, 2, 32'hC0);
        base_pulse(32'h300);
        send_pkt(2, 32'hC0);
        model_pkt(32'h400, 3, 32'hD0);
        fork
            send_pkt(3, 32'hD0);
            begin
                wait_inc("t4a inc");
                @(negedge clk);
                chk("t4 stall ready", {31'b0, bus.data_ready}, 32'd0);
                @(posedge clk);
                #1;
                base_pulse(32'h400);
            end
        join
        wait_inc("t4b inc");
        chk("t4 last addr", last_a, HDR ? 32'h400 : 32'h408);
        chk("t4 last data", last_d, HDR ? 32'd12 : 32'hD2);

        // Reset in the middle of a packet.
        model_pkt(32'h500, 5, 32'hE0);
        base_pulse(32'h500);
        bus.mem_ready = 1'b0;
        send_word(32'hE0, 1'b0);
        send_word(32'hE1, 1'b0);
        inc0 = inc_seen;
        n_rst = 1'b0;
        #1;
        chk_idle_outputs("mid reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.data_in = 32'hEEEE;
        bus.pkt_end = 1'b1;
        bus.data_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5 no base ready", {31'b0, bus.data_ready}, 32'd0);
        chk("t5 no inc", 32'(inc_seen - inc0), 32'd0);
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.pkt_end = 1'b0;

        // Single-word packet after the reset.
        w0 = wr_seen;
        model_pkt(32'h600, 1, 32'hF0);
        base_pulse(32'h600);
        send_pkt(1, 32'hF0);
        wait_inc("t6 inc");
        chk("t6 writes", 32'(wr_seen - w0), HDR ? 32'd2 : 32'd1);
        chk("t6 last data", last_d, HDR ? 32'd4 : 32'hF0);

        repeat (3) @(posedge clk);
        #1;
        chk("model drained", 32'(exp_q.size()), 32'd0);
        chk("inc pulses", 32'(inc_seen), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
